// File: rtl/hazard_mdu_if.sv
// Hazard-controller bundle: pipeline register addresses / Tuse / Tnew in, stall + forward selects out.
// Purely combinational wiring; no latency of its own.
// No backpressure: the controller's stall output is the only flow-control signal.
interface hazard_mdu_if;
  // D stage
  logic [4:0] regA1_D;
  logic [4:0] regA2_D;
  logic [1:0] Tuse_rs_D;
  logic [1:0] Tuse_rt_D;
  logic       mduInstr_D;
  // E stage
  logic [4:0] regA1_E;
  logic [4:0] regA2_E;
  logic [4:0] regA3_E;
  logic [2:0] Tnew_E;
  logic       start_E;
  logic       isDiv_E;
  // M stage
  logic [4:0] regA2_M;
  logic [4:0] regA3_M;
  logic [2:0] Tnew_M;
  // W stage
  logic [4:0] regA3_W;
  logic [2:0] Tnew_W;
  // Controller outputs
  logic        stall;
  logic        busy;
  logic [1:0]  regRD1Forward_D;
  logic [1:0]  regRD2Forward_D;
  logic [1:0]  regRD1Forward_E;
  logic [1:0]  regRD2Forward_E;
  logic        regRD2Forward_M;
  logic [31:0] stallCount;

  // Datapath side: drives pipeline state, consumes hazard decisions.
  modport master (
    output regA1_D, regA2_D, Tuse_rs_D, Tuse_rt_D, mduInstr_D,
    output regA1_E, regA2_E, regA3_E, Tnew_E, start_E, isDiv_E,
    output regA2_M, regA3_M, Tnew_M, regA3_W, Tnew_W,
    input  stall, busy, regRD1Forward_D, regRD2Forward_D,
    input  regRD1Forward_E, regRD2Forward_E, regRD2Forward_M, stallCount
  );

  // Controller side.
  modport slave (
    input  regA1_D, regA2_D, Tuse_rs_D, Tuse_rt_D, mduInstr_D,
    input  regA1_E, regA2_E, regA3_E, Tnew_E, start_E, isDiv_E,
    input  regA2_M, regA3_M, Tnew_M, regA3_W, Tnew_W,
    output stall, busy, regRD1Forward_D, regRD2Forward_D,
    output regRD1Forward_E, regRD2Forward_E, regRD2Forward_M, stallCount
  );
endinterface

// File: rtl/hazard_mdu_ctrl.sv
// Hazard controller for the 5-stage MIPS pipe: Tuse/Tnew stall, D/E/M forward selects, MDU busy timer.
// Stall and forward selects are combinational (0 cycles); busy/stallCount are registered.
// Backpressure: asserts stall to freeze PC/IF_ID and bubble ID_EX; never itself stalled.
module hazard_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  hazard_mdu_if.slave  hz
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // True when a D-stage operand must wait: its producer in E or M will not
  // have the value by the time the consumer reads it. Tuse = 3 means "unused".
  function automatic logic data_hazard(
    input logic [4:0] addr,
    input logic [1:0] tuse,
    input logic [4:0] a3_e,
    input logic [2:0] rem_e,
    input logic [4:0] a3_m,
    input logic [2:0] rem_m
  );
    logic [2:0] tuse_w;
    logic       hit_e;
    logic       hit_m;
    tuse_w = {1'b0, tuse};
    hit_e  = (addr == a3_e) && (rem_e > tuse_w);
    hit_m  = (addr == a3_m) && (rem_m > tuse_w);
    return (addr != 5'd0) && (tuse != 2'd3) && (hit_e || hit_m);
  endfunction

  // D-stage select: nearest ready producer wins; a not-yet-ready match falls
  // through to an older stage (the stall keeps that case from being consumed).
  function automatic logic [1:0] fwd_d(
    input logic [4:0] addr,
    input logic [4:0] a3_e,
    input logic [2:0] tnew_e,
    input logic [4:0] a3_m,
    input logic [2:0] tnew_m,
    input logic [4:0] a3_w
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (addr != 5'd0) begin
      if ((addr == a3_e) && (tnew_e == 3'd0))      sel = 2'd1;
      else if ((addr == a3_m) && (tnew_m <= 3'd1)) sel = 2'd2;
      else if (addr == a3_w)                       sel = 2'd3;
    end
    return sel;
  endfunction

  // E-stage select: M result if ready, else W result, else original.
  function automatic logic [1:0] fwd_e(
    input logic [4:0] addr,
    input logic [4:0] a3_m,
    input logic [2:0] tnew_m,
    input logic [4:0] a3_w
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (addr != 5'd0) begin
      if ((addr == a3_m) && (tnew_m <= 3'd1)) sel = 2'd1;
      else if (addr == a3_w)                  sel = 2'd2;
    end
    return sel;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic [2:0]  rem_e;
  logic [2:0]  rem_m;
  logic        stall_rs;
  logic        stall_rt;
  logic        stall_mdu;
  logic        busy_w;
  logic        stall_w;

  // Remaining cycles until each in-flight producer has its result.
  always_comb begin
    rem_e = hz.Tnew_E;
    rem_m = (hz.Tnew_M == 3'd0) ? 3'd0 : (hz.Tnew_M - 3'd1);
  end

  // Stall decision: data hazards on rs/rt plus MDU occupancy; forced low in reset.
  always_comb begin
    busy_w    = (cnt_q != 4'd0);
    stall_rs  = data_hazard(hz.regA1_D, hz.Tuse_rs_D, hz.regA3_E, rem_e, hz.regA3_M, rem_m);
    stall_rt  = data_hazard(hz.regA2_D, hz.Tuse_rt_D, hz.regA3_E, rem_e, hz.regA3_M, rem_m);
    stall_mdu = hz.mduInstr_D && (hz.start_E || busy_w);
    stall_w   = !reset && (stall_rs || stall_rt || stall_mdu);
  end

  // Forward selects for every stage that reads the register file.
  always_comb begin
    hz.regRD1Forward_D = fwd_d(hz.regA1_D, hz.regA3_E, hz.Tnew_E, hz.regA3_M, hz.Tnew_M, hz.regA3_W);
    hz.regRD2Forward_D = fwd_d(hz.regA2_D, hz.regA3_E, hz.Tnew_E, hz.regA3_M, hz.Tnew_M, hz.regA3_W);
    hz.regRD1Forward_E = fwd_e(hz.regA1_E, hz.regA3_M, hz.Tnew_M, hz.regA3_W);
    hz.regRD2Forward_E = fwd_e(hz.regA2_E, hz.regA3_M, hz.Tnew_M, hz.regA3_W);
    // W results are always final, so the store-data mux only needs an address match.
    hz.regRD2Forward_M = (hz.regA2_M != 5'd0) && (hz.regA2_M == hz.regA3_W);
  end

  // MDU countdown next state: a start reloads (even mid-count), otherwise drain to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (hz.start_E)          cnt_d = hz.isDiv_E ? DIV_LD : MULT_LD;
    else if (cnt_q != 4'd0)  cnt_d = cnt_q - 4'd1;
  end

  // Stall-cycle counter next state, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_w && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // MDU busy timer register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  // Performance counter register.
  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= 32'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  // Tnew_W is carried for completeness: a W-stage result is always final.
  logic unused_tnew_w;
  assign unused_tnew_w = ^hz.Tnew_W;

  assign hz.stall      = stall_w;
  assign hz.busy       = busy_w;
  assign hz.stallCount = stall_cnt_q;

endmodule
